tge_tx_packetizer: RTL and testbench

TGE_TX_PACKETIZER -- requirements
Module: tge_tx_packetizer

---
 rtl/tge_tx_packetizer_if.sv | 32 +++
 rtl/tge_tx_packetizer.sv | 151 +++++++++++++++
 tb/tb_tge_tx_packetizer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tge_tx_packetizer_if.sv
// Handshake/bus bundle between the sample source, the packetizer and the 10GbE core.
// The packetizer takes the slave side; the source/core side is the master.
interface tge_tx_packetizer_if;
  logic        enable;
  logic [31:0] dest_ip;
  logic [15:0] dest_port;
  logic        in_valid;
  logic [63:0] in_data;
  logic        tx_valid;
  logic        tx_end_of_frame;
  logic [63:0] tx_data;
  logic [31:0] tx_dest_ip;
  logic [15:0] tx_dest_port;
  logic        tx_afull;
  logic        tx_overflow;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;
  logic        fifo_overflow;
  logic        core_overflow;

  modport master (
    output enable, dest_ip, dest_port, in_valid, in_data, tx_afull, tx_overflow,
    input  tx_valid, tx_end_of_frame, tx_data, tx_dest_ip, tx_dest_port,
    input  pkt_count, drop_count, fifo_overflow, core_overflow
  );

  modport slave (
    input  enable, dest_ip, dest_port, in_valid, in_data, tx_afull, tx_overflow,
    output tx_valid, tx_end_of_frame, tx_data, tx_dest_ip, tx_dest_port,
    output pkt_count, drop_count, fifo_overflow, core_overflow
  );
endinterface

// File: rtl/tge_tx_packetizer.sv
// Packs a never-stalled 64-bit sample stream into fixed-length UDP frames for a 10GbE core,
// one header word {seq, PKT_ID} per frame; slots that cannot be sent are dropped whole.
module tge_tx_packetizer #(
  parameter int unsigned PAYLOAD_WORDS = 128,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter logic [15:0] PKT_ID        = 16'h0000
) (
  input logic                clk,
  input logic                rst,
  tge_tx_packetizer_if.slave bus
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam int unsigned WcW   = $clog2(PAYLOAD_WORDS) + 1;
  localparam logic [WcW-1:0]  WcLast  = WcW'(PAYLOAD_WORDS - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StHeader, StData, StDrop} state_e;

  state_e           state_q;
  logic [WcW-1:0]   wc_q;
  logic [47:0]      seq_q;
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [63:0]      mem_q [FIFO_DEPTH];

  logic        tx_valid_q, tx_eof_q;
  logic [63:0] tx_data_q;
  logic [31:0] tx_dest_ip_q;
  logic [15:0] tx_dest_port_q;
  logic [31:0] pkt_count_q, drop_count_q;
  logic        fifo_ovf_q, core_ovf_q;

  logic fifo_empty, start_ok, slot_last, pop, push, lost;

  always_comb begin
    fifo_empty = (count_q == '0);
    start_ok   = bus.enable && !bus.tx_afull;
    slot_last  = (wc_q == WcLast);
    pop        = 1'b0;
    case (state_q)
      // A drop decision discards the first word at once so DROP keeps pace with the source.
      StIdle:                   pop = !fifo_empty && !start_ok;
      StHeader, StData, StDrop: pop = !fifo_empty;
      default:                  pop = 1'b0;
    endcase
    push = bus.in_valid && ((count_q != CntFull) || pop);
    lost = bus.in_valid && !push;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      wc_q           <= '0;
      seq_q          <= '0;
      tx_valid_q     <= 1'b0;
      tx_eof_q       <= 1'b0;
      tx_data_q      <= '0;
      tx_dest_ip_q   <= '0;
      tx_dest_port_q <= '0;
      pkt_count_q    <= '0;
      drop_count_q   <= '0;
      fifo_ovf_q     <= 1'b0;
      core_ovf_q     <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      tx_eof_q   <= 1'b0;
      if (lost)            fifo_ovf_q <= 1'b1;
      if (bus.tx_overflow) core_ovf_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            seq_q <= seq_q + 48'd1;
            if (start_ok) begin
              tx_valid_q     <= 1'b1;
              tx_data_q      <= {seq_q, PKT_ID};
              tx_dest_ip_q   <= bus.dest_ip;
              tx_dest_port_q <= bus.dest_port;
              wc_q           <= '0;
              state_q        <= StHeader;
            end else if (slot_last) begin
              drop_count_q <= drop_count_q + 32'd1;
            end else begin
              wc_q    <= WcW'(1);
              state_q <= StDrop;
            end
          end
        end
        // HEADER already pops the first payload word so the frame leaves without a gap.
        StHeader, StData: begin
          if (!fifo_empty) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= mem_q[rd_ptr_q];
            if (slot_last) begin
              tx_eof_q    <= 1'b1;
              pkt_count_q <= pkt_count_q + 32'd1;
              wc_q        <= '0;
              state_q     <= StIdle;
            end else begin
              wc_q    <= wc_q + 1'b1;
              state_q <= StData;
            end
          end else begin
            state_q <= StData;
          end
        end
        StDrop: begin
          if (!fifo_empty) begin
            if (slot_last) begin
              drop_count_q <= drop_count_q + 32'd1;
              wc_q         <= '0;
              state_q      <= StIdle;
            end else begin
              wc_q <= wc_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.tx_valid        = tx_valid_q;
  assign bus.tx_end_of_frame = tx_eof_q;
  assign bus.tx_data         = tx_data_q;
  assign bus.tx_dest_ip      = tx_dest_ip_q;
  assign bus.tx_dest_port    = tx_dest_port_q;
  assign bus.pkt_count       = pkt_count_q;
  assign bus.drop_count      = drop_count_q;
  assign bus.fifo_overflow   = fifo_ovf_q;
  assign bus.core_overflow   = core_ovf_q;

endmodule

// File: tb/tb_tge_tx_packetizer.sv
// Scoreboard bench for tge_tx_packetizer with 4-word frames and a 4-entry FIFO.
module tb_tge_tx_packetizer;
  localparam int unsigned Pw = 4;
  localparam logic [15:0] PktId = 16'hA5C3;

  logic clk;
  logic rst;
  tge_tx_packetizer_if bus ();

  tge_tx_packetizer #(
    .PAYLOAD_WORDS(Pw),
    .FIFO_DEPTH   (4),
    .PKT_ID       (PktId)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] data;
    logic        eof;
    logic [31:0] ip;
    logic [15:0] port;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          sb_en = 1'b1;
  logic [47:0] seq_m = '0;
  int          pkt_m = 0;
  int          drop_m = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model one packet slot: header + payload when emitted, nothing when dropped.
  task automatic expect_slot(input bit emit, input logic [63:0] base);
    exp_t e;
    if (emit) begin
      e.ip = bus.dest_ip;
      e.port = bus.dest_port;
      e.data = {seq_m, PktId};
      e.eof = 1'b0;
      sb_q.push_back(e);
      for (int i = 0; i < int'(Pw); i++) begin
        e.data = base + 64'(i);
        e.eof = (i == int'(Pw) - 1);
        sb_q.push_back(e);
      end
      pkt_m++;
    end else begin
      drop_m++;
    end
    seq_m = seq_m + 48'd1;
  endtask

  task automatic drive_words(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = base + 64'(i);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
    idle(3);
    check_eq("drain", 64'(sb_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && sb_en) begin
      if (bus.tx_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_tx_valid", 64'(bus.tx_data), 64'hX);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("tx_data", bus.tx_data, e.data);
          check_eq("tx_eof", 64'(bus.tx_end_of_frame), 64'(e.eof));
          check_eq("tx_dest_ip", 64'(bus.tx_dest_ip), 64'(e.ip));
          check_eq("tx_dest_port", 64'(bus.tx_dest_port), 64'(e.port));
        end
      end else begin
        check_eq("eof_without_valid", 64'(bus.tx_end_of_frame), 64'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 64'(bus.tx_valid), 64'd0);
    check_eq({tag, "_eof"}, 64'(bus.tx_end_of_frame), 64'd0);
    check_eq({tag, "_data"}, bus.tx_data, 64'd0);
    check_eq({tag, "_ip"}, 64'(bus.tx_dest_ip), 64'd0);
    check_eq({tag, "_port"}, 64'(bus.tx_dest_port), 64'd0);
    check_eq({tag, "_pkt_count"}, 64'(bus.pkt_count), 64'd0);
    check_eq({tag, "_drop_count"}, 64'(bus.drop_count), 64'd0);
    check_eq({tag, "_fifo_ovf"}, 64'(bus.fifo_overflow), 64'd0);
    check_eq({tag, "_core_ovf"}, 64'(bus.core_overflow), 64'd0);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.dest_ip = 32'hC0A8_0A01;
    bus.dest_port = 16'd5000;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.tx_afull = 1'b0;
    bus.tx_overflow = 1'b0;
    idle(3);
    check_all_zero("reset");
    rst = 1'b0;
    bus.enable = 1'b1;
    idle(2);

    // Two back-to-back frames from 8 consecutive words.
    expect_slot(1'b1, 64'h1000);
    expect_slot(1'b1, 64'h1004);
    drive_words(8, 64'h1000);
    wait_drain();
    check_eq("pkt_count_2", 64'(bus.pkt_count), 64'(pkt_m));
    check_eq("fifo_ovf_clean", 64'(bus.fifo_overflow), 64'd0);

    // tx_afull at the slot decision drops the whole slot; seq still advances.
    bus.tx_afull = 1'b1;
    expect_slot(1'b0, 64'h2000);
    drive_words(4, 64'h2000);
    bus.tx_afull = 1'b0;
    idle(8);
    check_eq("drop_afull", 64'(bus.drop_count), 64'(drop_m));
    expect_slot(1'b1, 64'h2100);
    drive_words(4, 64'h2100);
    wait_drain();
    check_eq("pkt_after_drop", 64'(bus.pkt_count), 64'(pkt_m));

    // enable low with a continuous stream: DROP keeps up, no overflow.
    bus.enable = 1'b0;
    for (int s = 0; s < 10; s++) expect_slot(1'b0, 64'h3000);
    drive_words(40, 64'h3000);
    idle(10);
    bus.enable = 1'b1;
    check_eq("drop_stream", 64'(bus.drop_count), 64'(drop_m));
    check_eq("fifo_ovf_drop", 64'(bus.fifo_overflow), 64'd0);
    expect_slot(1'b1, 64'h3100);
    drive_words(4, 64'h3100);
    wait_drain();

    // Destination change mid-frame applies only from the next header; gaps inside a frame.
    expect_slot(1'b1, 64'h4000);
    drive_words(1, 64'h4000);
    idle(3);
    bus.dest_port = 16'd6000;
    bus.dest_ip = 32'h0A00_0002;
    drive_words(1, 64'h4001);
    idle(2);
    drive_words(2, 64'h4002);
    wait_drain();
    expect_slot(1'b1, 64'h4100);
    drive_words(4, 64'h4100);
    wait_drain();
    check_eq("pkt_count_dest", 64'(bus.pkt_count), 64'(pkt_m));

    // One-cycle tx_overflow pulse sets the sticky flag.
    check_eq("core_ovf_before", 64'(bus.core_overflow), 64'd0);
    bus.tx_overflow = 1'b1;
    idle(1);
    bus.tx_overflow = 1'b0;
    idle(5);
    check_eq("core_ovf_set", 64'(bus.core_overflow), 64'd1);

    // Sustained input outruns header overhead with a tiny FIFO: words are lost.
    sb_en = 1'b0;
    drive_words(40, 64'h5000);
    idle(60);
    check_eq("fifo_ovf_set", 64'(bus.fifo_overflow), 64'd1);
    check_eq("core_ovf_held", 64'(bus.core_overflow), 64'd1);

    rst = 1'b1;
    idle(2);
    check_all_zero("reset2");
    rst = 1'b0;
    sb_q.delete();
    seq_m = '0;
    pkt_m = 0;
    drop_m = 0;
    sb_en = 1'b1;
    idle(2);

    // Reset in the middle of DATA abandons the frame; next header restarts at seq 0.
    expect_slot(1'b1, 64'h6000);
    drive_words(2, 64'h6000);
    guard = 0;
    while (sb_q.size() > 3 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    check_eq("mid_data_reached", 64'(guard < 50), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid");
    sb_q.delete();
    seq_m = '0;
    pkt_m = 0;
    drop_m = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    expect_slot(1'b1, 64'h7000);
    drive_words(4, 64'h7000);
    wait_drain();
    check_eq("pkt_count_after_rst", 64'(bus.pkt_count), 64'(pkt_m));
    check_eq("drop_count_after_rst", 64'(bus.drop_count), 64'(drop_m));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
